// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the dual-clock CDC FIFO: default geometry and pointer code conversions.
package cdc_fifo_pkg;

   // Default memory index width; the FIFO holds 2**AddrWidthDefault entries.
   localparam int unsigned AddrWidthDefault = 3;

   // Widest pointer the conversion helpers accept. Callers zero-extend to this width
   // and cast the result back to their pointer width.
   localparam int unsigned PtrMaxW = 32;

   typedef logic [PtrMaxW-1:0] ptr_word_t;

   // Binary to reflected Gray code. Consecutive binary values differ in one Gray bit.
   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary over the low 'width' bits. Each binary bit is the XOR of every
   // Gray bit at or above it, so the prefix runs down from the MSB.
   // Bits above 'width' are passed through and are expected to be zero.
   function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int unsigned width);
      ptr_word_t bin;
      bin = gray;
      for (int i = int'(width) - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/read_control_logic.sv
// Read-side pointer and flag controller of the dual-clock CDC FIFO.
// Advances the read pointer on accepted reads, publishes it in Gray code for the
// write domain, and derives empty / almost-empty / level / underflow from the write
// pointer that has already been synchronised into read_clk.
module read_control_logic
   import cdc_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH          = AddrWidthDefault,
   parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
   input  logic                  read_clk,
   input  logic                  read_rst,
   input  logic                  read_enable_in,
   input  logic [ADDR_WIDTH:0]   write_addr_gray_sync,
   output logic [ADDR_WIDTH:0]   read_addr_gray,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic                  read_enable_out,
   output logic                  read_data_valid,
   output logic                  fifo_empty,
   output logic                  fifo_almost_empty,
   output logic [ADDR_WIDTH:0]   read_level,
   output logic                  read_underflow
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int unsigned PtrW = ADDR_WIDTH + 1;
   localparam logic [PtrW-1:0] Thresh = PtrW'(ALMOST_EMPTY_THRESH);

   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [PtrW-1:0] gray_q, gray_d;
   logic [PtrW-1:0] level_q, level_d;
   logic [PtrW-1:0] wbin;
   logic            empty_q, empty_d;
   logic            aempty_q, aempty_d;
   logic            valid_q, valid_d;
   logic            underflow_q, underflow_d;

   // Read acceptance, next pointer and next flags, all from the pointer after this read.
   always_comb begin
      // A read is never accepted while empty or during reset, so the RAM is never over-read.
      read_enable_out = read_enable_in & ~empty_q & ~read_rst;
      rptr_d          = rptr_q + {{ADDR_WIDTH{1'b0}}, read_enable_out};
      wbin            = PtrW'(gray2bin(PtrMaxW'(write_addr_gray_sync), PtrW));
      gray_d          = PtrW'(bin2gray(PtrMaxW'(rptr_d)));
      // Modular difference; the write side guarantees it never exceeds the depth.
      level_d         = wbin - rptr_d;
      // Compare in Gray space so a stale synchronised pointer can only hold empty longer.
      empty_d         = (gray_d == write_addr_gray_sync);
      aempty_d        = (level_d <= Thresh);
      valid_d         = read_enable_out;
      underflow_d     = read_enable_in & empty_q & ~read_rst;
   end

   // Pointer, flag and strobe registers with synchronous reset.
   always_ff @(posedge read_clk) begin
      if (read_rst) begin
         rptr_q      <= '0;
         gray_q      <= '0;
         level_q     <= '0;
         empty_q     <= 1'b1;
         aempty_q    <= 1'b1;
         valid_q     <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rptr_q      <= rptr_d;
         gray_q      <= gray_d;
         level_q     <= level_d;
         empty_q     <= empty_d;
         aempty_q    <= aempty_d;
         valid_q     <= valid_d;
         underflow_q <= underflow_d;
      end
   end

   assign read_addr_gray    = gray_q;
   assign read_addr         = rptr_q[ADDR_WIDTH-1:0];
   assign read_level        = level_q;
   assign fifo_empty        = empty_q;
   assign fifo_almost_empty = aempty_q;
   assign read_data_valid   = valid_q;
   assign read_underflow    = underflow_q;

endmodule

// File: tb/tb_read_control_logic.sv
// Self-checking bench for read_control_logic: directed steps followed by random traffic,
// compared against an entry-counting model of the FIFO read side.
module tb_read_control_logic;

   localparam int unsigned AW     = 3;
   localparam int unsigned THRESH = 2;
   localparam int          DEPTH  = 1 << AW;
   localparam int          PMOD   = 2 * DEPTH;

   logic          read_clk = 1'b0;
   logic          read_rst;
   logic          read_enable_in;
   logic [AW:0]   write_addr_gray_sync;
   logic [AW:0]   read_addr_gray;
   logic [AW-1:0] read_addr;
   logic          read_enable_out;
   logic          read_data_valid;
   logic          fifo_empty;
   logic          fifo_almost_empty;
   logic [AW:0]   read_level;
   logic          read_underflow;

   read_control_logic #(
      .ADDR_WIDTH          (AW),
      .ALMOST_EMPTY_THRESH (THRESH)
   ) dut (
      .read_clk             (read_clk),
      .read_rst             (read_rst),
      .read_enable_in       (read_enable_in),
      .write_addr_gray_sync (write_addr_gray_sync),
      .read_addr_gray       (read_addr_gray),
      .read_addr            (read_addr),
      .read_enable_out      (read_enable_out),
      .read_data_valid      (read_data_valid),
      .fifo_empty           (fifo_empty),
      .fifo_almost_empty    (fifo_almost_empty),
      .read_level           (read_level),
      .read_underflow       (read_underflow)
   );

   always #5 read_clk = ~read_clk;

   int checks   = 0;
   int failures = 0;

   // Model: total entries written (w) and read (m_rd) since the last reset, plus the
   // values the registered outputs must show after the most recent edge.
   int   w      = 0;
   int   m_rd   = 0;
   int   m_level = 0;
   logic m_empty, m_aempty, m_valid, m_uf;
   logic m_known = 1'b0;

   function automatic int gray_of(input int v);
      int m;
      m = v % PMOD;
      return m ^ (m >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One read-domain cycle: writer advances by wadv, inputs applied, outputs checked
   // mid-cycle, then the model steps across the edge.
   task automatic step(input logic rst, input logic ren, input int wadv);
      logic exp_reo;
      int   lvl;
      if (rst) w = 0;
      else     w = w + wadv;
      read_rst             = rst;
      read_enable_in       = ren;
      write_addr_gray_sync = (AW+1)'(gray_of(w));
      @(negedge read_clk);
      exp_reo = ren & ~m_empty & ~rst;
      if (m_known) begin
         chk("read_enable_out",   32'(read_enable_out),   32'(exp_reo));
         chk("read_addr",         32'(read_addr),         32'(m_rd % DEPTH));
         chk("read_addr_gray",    32'(read_addr_gray),    32'(gray_of(m_rd)));
         chk("fifo_empty",        32'(fifo_empty),        32'(m_empty));
         chk("fifo_almost_empty", 32'(fifo_almost_empty), 32'(m_aempty));
         chk("read_level",        32'(read_level),        32'(m_level));
         chk("read_data_valid",   32'(read_data_valid),   32'(m_valid));
         chk("read_underflow",    32'(read_underflow),    32'(m_uf));
      end
      @(posedge read_clk);
      if (rst) begin
         m_rd    = 0;
         m_level = 0;
         m_empty = 1'b1;
         m_aempty = 1'b1;
         m_valid = 1'b0;
         m_uf    = 1'b0;
         m_known = 1'b1;
      end else begin
         m_uf = ren & m_empty;
         if (exp_reo) m_rd++;
         lvl = w - m_rd;
         // The writer must never run more than DEPTH entries ahead.
         assert (lvl >= 0 && lvl <= DEPTH)
         else begin
            failures++;
            $error("FAIL protocol_level observed=%0d expected=0..%0d", lvl, DEPTH);
         end
         m_level  = lvl;
         m_empty  = (lvl == 0);
         m_aempty = (lvl <= int'(THRESH));
         m_valid  = exp_reo;
      end
      #1;
   endtask

   initial begin
      int room;
      read_rst             = 1'b1;
      read_enable_in       = 1'b0;
      write_addr_gray_sync = '0;
      m_empty  = 1'b1;
      m_aempty = 1'b1;
      m_valid  = 1'b0;
      m_uf     = 1'b0;

      // Reset held for two cycles.
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);

      // Three entries appear, then drain them with reads held high, plus one extra.
      step(1'b0, 1'b0, 3);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 0);

      // Single read while empty.
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);

      // Writer stays four ahead through 16 reads: two full pointer laps of the index.
      step(1'b0, 1'b0, 4);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 0);

      // Full FIFO from pointer 0, read down through almost-empty, then read+write at level 1.
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, DEPTH);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b0, 0);

      // Reset mid-stream with the read pointer at 5.
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, DEPTH);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0);
      step(1'b1, 1'b1, 0);
      step(1'b0, 1'b0, 0);

      // Random traffic with occasional resets; writer never exceeds the free space.
      for (int i = 0; i < 400; i++) begin
         room = DEPTH - (w - m_rd);
         if ($urandom_range(0, 49) == 0) begin
            step(1'b1, 1'($urandom_range(0, 1)), 0);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, (room < 2) ? room : 2)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
